// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator-side front end for a small synchronous ALU. Commands (op, A, B)
// arrive over a valid/ready interface and are queued in a DEPTH-entry FIFO.
// One command at a time is driven onto the ALU inputs. The block waits
// ALU_LAT edges for the ALU's registered result, captures result/status,
// and returns them in command order over a second valid/ready interface.
//
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready     command handshake; i_cmd_op/a/b payload
//   o_alu_op/arg_A/arg_B        registered ALU inputs, stable between issues
//   i_alu_result/i_alu_status   ALU outputs, sampled in CAPTURE
//   o_rsp_valid/i_rsp_ready     response handshake; o_rsp_op/result/status
//   o_count                     FIFO occupancy
//   o_busy                      FSM not idle or FIFO not empty
module alu_cmd_sequencer #(
  parameter int N       = 2,
  parameter int M       = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [N-1:0]             i_cmd_op,
  input  logic [M-1:0]             i_cmd_a,
  input  logic [M-1:0]             i_cmd_b,
  output logic [N-1:0]             o_alu_op,
  output logic [M-1:0]             o_alu_arg_A,
  output logic [M-1:0]             o_alu_arg_B,
  input  logic [M-1:0]             i_alu_result,
  input  logic [3:0]               i_alu_status,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [N-1:0]             o_rsp_op,
  output logic [M-1:0]             o_rsp_result,
  output logic [3:0]               o_rsp_status,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(ALU_LAT + 1);
  localparam int DW = N + 2 * M;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [LW-1:0] WAIT_LOAD  = LW'(ALU_LAT);
  localparam logic [LW-1:0] WAIT_ONE   = LW'(1);
  localparam logic [LW-1:0] WAIT_ZERO  = LW'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } state_t;

  // FIFO storage and bookkeeping
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Sequencer state and registered outputs
  state_t        state_q, state_d;
  logic [LW-1:0] wait_q, wait_d;
  logic [N-1:0]  alu_op_q, alu_op_d;
  logic [M-1:0]  alu_a_q, alu_a_d;
  logic [M-1:0]  alu_b_q, alu_b_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_op_q, rsp_op_d;
  logic [M-1:0]  rsp_result_q, rsp_result_d;
  logic [3:0]    rsp_status_q, rsp_status_d;
  logic          busy_q, busy_d;

  logic          cmd_ready_s;
  logic          push_s;
  logic          pop_s;
  logic [DW-1:0] head_s;

  // Ready depends on occupancy only, so a full FIFO simply stalls the source.
  assign cmd_ready_s = (count_q != COUNT_FULL);
  assign push_s      = i_cmd_valid && cmd_ready_s;
  assign pop_s       = (state_q == ST_IDLE) && (count_q != COUNT_ZERO);
  assign head_s      = mem_q[rd_ptr_q];

  // Write the incoming command into the slot at the write pointer.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {i_cmd_op, i_cmd_a, i_cmd_b};
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Sequencer next-state: issue head, wait ALU latency, capture, hand back.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != COUNT_ZERO) begin
          alu_op_d = head_s[DW-1 -: N];
          alu_a_d  = head_s[2*M-1 -: M];
          alu_b_d  = head_s[M-1:0];
          wait_d   = WAIT_LOAD;
          state_d  = ST_ISSUE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        wait_d = wait_q - WAIT_ONE;
        if (wait_q == WAIT_ONE) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_CAPTURE: begin
        rsp_result_d = i_alu_result;
        rsp_status_d = i_alu_status;
        rsp_op_d     = alu_op_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE) || (count_d != COUNT_ZERO);
  end

  // State registers; reset drops queued and in-flight commands.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= COUNT_ZERO;
      state_q      <= ST_IDLE;
      wait_q       <= WAIT_ZERO;
      alu_op_q     <= {N{1'b0}};
      alu_a_q      <= {M{1'b0}};
      alu_b_q      <= {M{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= {N{1'b0}};
      rsp_result_q <= {M{1'b0}};
      rsp_status_q <= 4'b0000;
      busy_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      wait_q       <= wait_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
      busy_q       <= busy_d;
    end
  end

  assign o_cmd_ready  = cmd_ready_s;
  assign o_alu_op     = alu_op_q;
  assign o_alu_arg_A  = alu_a_q;
  assign o_alu_arg_B  = alu_b_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_op     = rsp_op_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_status = rsp_status_q;
  assign o_count      = count_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer. A registered one-cycle ALU stub
// answers the DUT; accepted commands push a hand-computed expected response
// and a negedge monitor pops and compares each response handshake.
// Stub: op00 A-2B, op01 A>B (unsigned) ? 1 : 0, op10 A+B, op11 two's
// complement to sign-magnitude. Status = {result==0, result[3], op}.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_op;
  logic [3:0] i_cmd_a, i_cmd_b;
  logic [1:0] o_alu_op;
  logic [3:0] o_alu_arg_A, o_alu_arg_B;
  logic [3:0] i_alu_result, i_alu_status;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [1:0] o_rsp_op;
  logic [3:0] o_rsp_result, o_rsp_status;
  logic [2:0] o_count;
  logic       o_busy;

  typedef struct {
    logic [1:0] op;
    logic [3:0] res;
    logic [3:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] alu_pair;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.N(2), .M(4), .DEPTH(4), .ALU_LAT(1)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .o_alu_op(o_alu_op), .o_alu_arg_A(o_alu_arg_A), .o_alu_arg_B(o_alu_arg_B),
    .i_alu_result(i_alu_result), .i_alu_status(i_alu_status),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_op(o_rsp_op), .o_rsp_result(o_rsp_result), .o_rsp_status(o_rsp_status),
    .o_count(o_count), .o_busy(o_busy)
  );

  function automatic logic [7:0] alu_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] neg;
    neg = 4'd0 - a;
    case (op)
      2'b00:   r = a - {b[2:0], 1'b0};
      2'b01:   r = (a > b) ? 4'd1 : 4'd0;
      2'b10:   r = a + b;
      default: r = a[3] ? {1'b1, neg[2:0]} : a;
    endcase
    return {(r == 4'd0), r[3], op, r};
  endfunction

  // Registered ALU stub: one edge of latency.
  always @(posedge clk) alu_pair <= alu_model(o_alu_op, o_alu_arg_A, o_alu_arg_B);
  assign i_alu_result = alu_pair[3:0];
  assign i_alu_status = alu_pair[7:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (o_rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got op %0h result %0h with nothing expected", o_rsp_op, o_rsp_result);
      end else if (i_rsp_ready === 1'b1) begin
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        if (o_rsp_op !== e.op || o_rsp_result !== e.res || o_rsp_status !== e.st) begin
          n_fail++;
          $display("FAIL rsp: got op %0h res %0h st %0h expected op %0h res %0h st %0h",
                   o_rsp_op, o_rsp_result, o_rsp_status, e.op, e.res, e.st);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] r, input logic [3:0] s);
    logic accepted;
    accepted    = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_a     = a;
    i_cmd_b     = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_cmd_ready === 1'b1) begin
        exp_q.push_back('{op, r, s});
        accepted = 1'b1;
      end
      tick();
      if (accepted) break;
    end
    i_cmd_valid = 1'b0;
    check("push_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 50 && o_rsp_valid !== 1'b1; i++) tick();
    check("rsp_wait", {31'd0, o_rsp_valid}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || o_busy !== 1'b0); i++) tick();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Single command into an idle, empty block with i_rsp_ready=1; checks exact latency.
  task automatic single_latency(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] r, input logic [3:0] s);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_a     = a;
    i_cmd_b     = b;
    check("lat_ready", {31'd0, o_cmd_ready}, 32'd1);
    exp_q.push_back('{op, r, s});
    tick();                                      // edge k
    i_cmd_valid = 1'b0;
    check("lat_count_k", o_count, 32'd1);
    tick();                                      // edge k+1
    check("lat_alu_op", o_alu_op, op);
    check("lat_alu_a", o_alu_arg_A, a);
    check("lat_alu_b", o_alu_arg_B, b);
    check("lat_count_k1", o_count, 32'd0);
    check("lat_valid_k1", o_rsp_valid, 32'd0);
    tick();                                      // edge k+2
    check("lat_valid_k2", o_rsp_valid, 32'd0);
    tick();                                      // edge k+3
    check("lat_valid_k3", o_rsp_valid, 32'd1);
    check("lat_result_k3", o_rsp_result, r);
    tick();                                      // edge k+4
    check("lat_valid_drop", o_rsp_valid, 32'd0);
  endtask

  // 10 sequential commands: op, A, B, expected result, expected status.
  logic [17:0] seq_tab [10] = '{
    {2'b00, 4'b1010, 4'b0011, 4'b0100, 4'b0000},
    {2'b01, 4'b0011, 4'b0011, 4'b0000, 4'b1001},
    {2'b10, 4'b1111, 4'b0001, 4'b0000, 4'b1010},
    {2'b11, 4'b0101, 4'b0000, 4'b0101, 4'b0011},
    {2'b11, 4'b1111, 4'b0000, 4'b1001, 4'b0111},
    {2'b01, 4'b1111, 4'b0000, 4'b0001, 4'b0001},
    {2'b00, 4'b0001, 4'b0001, 4'b1111, 4'b0100},
    {2'b10, 4'b0110, 4'b0111, 4'b1101, 4'b0110},
    {2'b00, 4'b0100, 4'b0010, 4'b0000, 4'b1000},
    {2'b11, 4'b1000, 4'b0000, 4'b1000, 4'b0111}
  };

  initial begin
    i_reset     = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'b10;
    i_cmd_a     = 4'b0101;
    i_cmd_b     = 4'b0011;
    i_rsp_ready = 1'b0;

    // 1. Reset held two edges with a command offered.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", o_cmd_ready, 32'd1);
    check("rst_count", o_count, 32'd0);
    check("rst_valid", o_rsp_valid, 32'd0);
    check("rst_alu", {o_alu_op, o_alu_arg_A, o_alu_arg_B}, 32'd0);
    check("rst_rsp", {o_rsp_op, o_rsp_result, o_rsp_status}, 32'd0);
    i_reset     = 1'b0;
    i_cmd_valid = 1'b0;
    tick();
    check("rst_no_push", o_count, 32'd0);
    check("rst_busy", o_busy, 32'd0);

    // 2. Single SUB with exact latency.
    i_rsp_ready = 1'b1;
    single_latency(2'b00, 4'b0111, 4'b0010, 4'b0011, 4'b0000);

    // 3. Fill with responses blocked, then drain in order.
    i_rsp_ready = 1'b0;
    push_cmd(2'b01, 4'b1000, 4'b0011, 4'b0001, 4'b0001);
    push_cmd(2'b10, 4'b0011, 4'b0001, 4'b0100, 4'b0010);
    push_cmd(2'b11, 4'b1101, 4'b0000, 4'b1011, 4'b0111);
    push_cmd(2'b00, 4'b0111, 4'b0010, 4'b0011, 4'b0000);
    push_cmd(2'b10, 4'b0101, 4'b0101, 4'b1010, 4'b0110);
    fork
      push_cmd(2'b00, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
      begin
        repeat (3) tick();
        check("fill_count", o_count, 32'd4);
        check("fill_ready", o_cmd_ready, 32'd0);
        check("fill_head_valid", o_rsp_valid, 32'd1);
        check("fill_head_result", o_rsp_result, 32'h1);
        i_rsp_ready = 1'b1;
      end
    join
    drain();

    // 4. Backpressure with one command queued behind a pending response.
    i_rsp_ready = 1'b0;
    push_cmd(2'b10, 4'b0010, 4'b0011, 4'b0101, 4'b0010);
    push_cmd(2'b01, 4'b0010, 4'b0101, 4'b0000, 4'b1001);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp", {o_rsp_valid, o_rsp_op, o_rsp_result, o_rsp_status}, {1'b1, 2'b10, 4'b0101, 4'b0010});
      check("bp_alu", {o_alu_op, o_alu_arg_A, o_alu_arg_B}, {2'b10, 4'b0010, 4'b0011});
      check("bp_count", o_count, 32'd1);
    end
    i_rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", o_rsp_valid, 32'd0);
    check("bp_no_early_issue", o_alu_op, 32'h2);
    tick();
    check("bp_next_issue", {o_alu_op, o_alu_arg_A, o_alu_arg_B}, {2'b01, 4'b0010, 4'b0101});
    check("bp_next_count", o_count, 32'd0);
    drain();

    // 5. Reset during ISSUE with two commands still queued.
    i_rsp_ready = 1'b0;
    push_cmd(2'b10, 4'b0001, 4'b0001, 4'b0010, 4'b0010);
    push_cmd(2'b11, 4'b1100, 4'b0000, 4'b1100, 4'b0111);
    push_cmd(2'b00, 4'b0011, 4'b0001, 4'b0001, 4'b0000);
    push_cmd(2'b01, 4'b0100, 4'b0001, 4'b0001, 4'b0001);
    wait_rsp();
    check("mid_count3", o_count, 32'd3);
    i_rsp_ready = 1'b1;
    tick();
    check("mid_idle", o_rsp_valid, 32'd0);
    tick();
    check("mid_issue_op", o_alu_op, 32'h3);
    check("mid_count2", o_count, 32'd2);
    i_reset = 1'b1;
    exp_q.delete();
    tick();
    i_reset = 1'b0;
    check("mid_rst_count", o_count, 32'd0);
    check("mid_rst_busy", o_busy, 32'd0);
    check("mid_rst_valid", o_rsp_valid, 32'd0);
    check("mid_rst_alu", {o_alu_op, o_alu_arg_A, o_alu_arg_B}, 32'd0);
    repeat (6) tick();
    check("mid_quiet", {o_rsp_valid, o_busy}, 32'd0);
    single_latency(2'b10, 4'b0100, 4'b0100, 4'b1000, 4'b0110);

    // 6. Push and pop on the same edge, then a wrapping run of 10.
    i_rsp_ready = 1'b0;
    push_cmd(2'b01, 4'b0110, 4'b0010, 4'b0001, 4'b0001);
    push_cmd(2'b11, 4'b1110, 4'b0000, 4'b1010, 4'b0111);
    push_cmd(2'b00, 4'b1000, 4'b0001, 4'b0110, 4'b0000);
    wait_rsp();
    check("pp_count_pre", o_count, 32'd2);
    i_rsp_ready = 1'b1;
    tick();
    check("pp_idle", o_rsp_valid, 32'd0);
    check("pp_count_idle", o_count, 32'd2);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'b10;
    i_cmd_a     = 4'b0001;
    i_cmd_b     = 4'b0010;
    check("pp_ready", o_cmd_ready, 32'd1);
    exp_q.push_back('{2'b10, 4'b0011, 4'b0010});
    tick();
    i_cmd_valid = 1'b0;
    check("pp_count_same", o_count, 32'd2);
    check("pp_issue_op", o_alu_op, 32'h3);
    drain();

    for (int i = 0; i < 10; i++) begin
      logic [17:0] v;
      v = seq_tab[i];
      push_cmd(v[17:16], v[15:12], v[11:8], v[7:4], v[3:0]);
    end
    drain();
    check("final_busy", o_busy, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
